sa_ram_rd_stream_128x11: RTL and testbench
==========================================

SA_RAM_RD_STREAM_128X11 -- requirements
Module: sa_ram_rd_stream_128x11

Interface
REQ-001 SHALL have port nvdla_core_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-002 SHALL have port nvdla_core_rstn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port cmd_valid, input, 1 bit: burst command valid.
REQ-004 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high.
REQ-005 SHALL have port cmd_addr, input, 7 bits: start word address.
REQ-006 SHALL have port cmd_len, input, 7 bits: burst length minus 1 (1..128 words).
REQ-007 SHALL have port ram_ra, output, 7 bits: RAM read address.
REQ-008 SHALL have port ram_re, output, 1 bit: RAM read-address capture enable.
REQ-009 SHALL have port ram_ore, output, 1 bit: RAM output-register enable.
REQ-010 SHALL have port ram_dout, input, 11 bits: RAM registered read data.
REQ-011 SHALL have port dout_valid, output, 1 bit: stream word valid.
REQ-012 SHALL have port dout_ready, input, 1 bit: consumer ready.
REQ-013 SHALL have port dout_pd, output, 11 bits: stream data.
REQ-014 SHALL have port dout_last, output, 1 bit: marks the final word of a burst.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, then RUN on accept, then DRAIN when the last read is issued, then IDLE when the last word pops.
REQ-016 SHALL drive cmd_ready=1 only in IDLE; a command is captured in the acceptance cycle.
REQ-017 SHALL, in RUN, issue one read per cycle (ram_re=1, ram_ra=current address) whenever a credit is available.
REQ-018 SHALL increment the address mod 128 after each issue; 127 wraps to 0.
REQ-019 SHALL issue exactly cmd_len+1 reads per burst.
REQ-020 SHALL treat RAM read latency as fixed: read issued in cycle T => ram_ore=1 in cycle T+1 => ram_dout sampled valid in cycle T+2.
REQ-021 SHALL drive ram_ore from a 1-bit issue pipeline register only, never asserted otherwise.
REQ-022 SHALL write each returned word plus its last flag into a 4-entry skid FIFO in cycle T+2 unconditionally.
REQ-023 SHALL issue a read only if FIFO occupancy + in-flight reads (0..2) < 4, so the FIFO never overflows.
REQ-024 SHALL sustain 1 word/cycle when dout_ready is held high.
REQ-025 SHALL present the FIFO head on dout_pd/dout_last with dout_valid=!empty; a pop occurs on dout_valid&&dout_ready.
REQ-026 SHALL keep dout_pd/dout_last stable while dout_valid=1 and dout_ready=0.
REQ-027 SHALL, on simultaneous FIFO push and pop, keep occupancy unchanged; a push to an empty FIFO becomes visible the next cycle (no bypass).
REQ-028 SHALL assert dout_last only on word cmd_len+1 of a burst.
REQ-029 SHALL hold ram_ra at its last value when ram_re=0.
REQ-030 SHALL ignore cmd_* outside IDLE.

Reset
REQ-031 SHALL, on nvdla_core_rstn low (async), force: FSM=IDLE, cmd_ready=1 after deassert, ram_re=0, ram_ore=0, ram_ra=0, dout_valid=0, dout_pd=0, dout_last=0, FIFO empty, counters=0.
REQ-032 SHALL discard all in-flight reads and FIFO contents on a mid-burst reset; no partial burst resumes.

Structure
REQ-033 SHALL hold RAM_AW=7, RAM_DW=11, SKID_DEPTH=4 and the FSM state encodings in the shared package/include.
REQ-034 SHALL instantiate one sub-module, sa_ram_rd_skid_fifo (12-bit wide, 4 deep, registered output, full/empty/count).
REQ-035 SHALL have RTL totalling 120-400 lines.

Verification
REQ-036 SHALL cover: RAM preloaded M[i]=i; cmd addr=5, len=3, dout_ready=1 -> dout_pd 5,6,7,8 on consecutive cycles, last on 8, first ram_re in cycle after accept.
REQ-037 SHALL cover: cmd addr=126, len=3 -> ram_ra 126,127,0,1; data 126,127,0,1.
REQ-038 SHALL cover: len=127, dout_ready=0 for 20 cycles -> exactly 4 ram_re pulses, dout_valid=1 with pd stable; on release, 128 words in order with no loss or duplication.
REQ-039 SHALL cover: random dout_ready toggling, len=15 -> 16 words in order, FIFO occupancy never >4, ram_ore always one cycle after ram_re.
REQ-040 SHALL cover: reset asserted at word 3 of a len=9 burst -> all outputs zero immediately; a new cmd addr=0, len=0 afterwards -> single word M[0] with last=1.
REQ-041 SHALL cover: cmd_valid held during RUN -> cmd_ready=0, second command accepted only after the last pop returns to IDLE.

Source files
------------

// File: rtl/sa_ram_rd_stream_128x11_pkg.sv
// Shared widths, skid FIFO geometry and FSM encodings for the RAM read streamer.
package sa_ram_rd_stream_128x11_pkg;

    localparam int RAM_AW     = 7;
    localparam int RAM_DW     = 11;
    localparam int SKID_DEPTH = 4;
    localparam int SKID_W     = RAM_DW + 1;
    localparam int CNT_W      = $clog2(SKID_DEPTH) + 1;
    localparam int IDX_W      = $clog2(SKID_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic              last;
        logic [RAM_DW-1:0] data;
    } skid_word_t;

    function automatic logic [RAM_AW-1:0] addr_inc(input logic [RAM_AW-1:0] a);
        return a + 1'b1;
    endfunction

endpackage

// File: rtl/sa_ram_rd_skid_fifo.sv
// Shift-style skid FIFO; entry 0 is the head and drives dout straight from a flop.
module sa_ram_rd_skid_fifo
    import sa_ram_rd_stream_128x11_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [SKID_W-1:0] din,
    output logic [SKID_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [SKID_W-1:0] mem_q [SKID_DEPTH];
    logic [SKID_W-1:0] mem_d [SKID_DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  widx;
    logic              do_pop;
    logic              do_push;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(SKID_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign widx    = do_pop ? (cnt_q - 1'b1) : cnt_q;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (do_pop) begin
            for (int i = 0; i < SKID_DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[SKID_DEPTH-1] = '0;
            cnt_d = cnt_q - 1'b1;
        end
        // write lands behind the shifted entries, so a push to empty shows next cycle
        if (do_push) begin
            mem_d[widx[IDX_W-1:0]] = din;
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[0];
    assign count = cnt_q;

endmodule

// File: rtl/sa_ram_rd_stream_128x11.sv
// Burst read streamer: issues credit-limited RAM reads and streams words out via a skid FIFO.
//   state    | meaning
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_RUN   | issuing reads while FIFO + in-flight credits allow
//   ST_DRAIN | all reads issued, waiting for the last word to pop
module sa_ram_rd_stream_128x11
    import sa_ram_rd_stream_128x11_pkg::*;
(
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [RAM_AW-1:0] cmd_addr,
    input  logic [RAM_AW-1:0] cmd_len,
    output logic [RAM_AW-1:0] ram_ra,
    output logic              ram_re,
    output logic              ram_ore,
    input  logic [RAM_DW-1:0] ram_dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [RAM_DW-1:0] dout_pd,
    output logic              dout_last
);

    logic [1:0]        state_q, state_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [RAM_AW-1:0] rem_q, rem_d;
    logic [RAM_AW-1:0] ra_hold_q, ra_hold_d;
    logic              ore_q, ore_d;
    logic              last1_q, last1_d;
    logic              vld2_q, vld2_d;
    logic              last2_q, last2_d;

    logic              issue;
    logic              issue_last;
    logic              credit;
    logic [CNT_W:0]    occ;
    logic              pop;
    logic [SKID_W-1:0] fifo_din;
    logic [SKID_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    skid_word_t        head;

    // in-flight reads hold FIFO slots until they land, so count them as occupied
    assign occ = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, ore_q} + {{CNT_W{1'b0}}, vld2_q};
    assign credit     = !fifo_full && (occ < (CNT_W+1)'(SKID_DEPTH));
    assign issue      = (state_q == ST_RUN) && credit;
    assign issue_last = issue && (rem_q == '0);
    assign pop        = dout_valid && dout_ready;
    assign head       = skid_word_t'(fifo_dout);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        ra_hold_d = issue ? addr_q : ra_hold_q;
        ore_d     = issue;
        last1_d   = issue_last;
        vld2_d    = ore_q;
        last2_d   = last1_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = addr_inc(addr_q);
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head.last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            ra_hold_q <= '0;
            ore_q     <= 1'b0;
            last1_q   <= 1'b0;
            vld2_q    <= 1'b0;
            last2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            ra_hold_q <= ra_hold_d;
            ore_q     <= ore_d;
            last1_q   <= last1_d;
            vld2_q    <= vld2_d;
            last2_q   <= last2_d;
        end
    end

    assign fifo_din = {last2_q, ram_dout};

    sa_ram_rd_skid_fifo u_skid (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .push  (vld2_q),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign cmd_ready  = (state_q == ST_IDLE);
    assign ram_re     = issue;
    assign ram_ra     = issue ? addr_q : ra_hold_q;
    assign ram_ore    = ore_q;
    assign dout_valid = !fifo_empty;
    assign dout_pd    = head.data;
    assign dout_last  = head.last;

endmodule

// File: tb/tb_sa_ram_rd_stream_128x11.sv
// Bench for the RAM read streamer: behavioural RAM, queue-based stream model, random back-pressure.
module tb_sa_ram_rd_stream_128x11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_addr = '0;
    logic [6:0]  cmd_len = '0;
    logic [6:0]  ram_ra;
    logic        ram_re;
    logic        ram_ore;
    logic [10:0] ram_dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic [10:0] dout_pd;
    logic        dout_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;

    logic [10:0] mem [128];
    logic [6:0]  ra_lat = '0;
    logic [10:0] dout_reg = '0;

    // model state
    bit  busy = 0;
    int  exp_pd[$];
    bit  exp_last[$];
    int  exp_ra[$];
    int  outst = 0;
    bit  prev_re = 0;
    bit  prev_stall = 0;
    int  prev_word = 0;
    int  last_ra = 0;
    bit  first_re_pending = 0;
    int  first_re_due = 0;

    // logs for directed literal checks
    int  acc_cyc[$];
    int  re_log[$];
    int  pop_pd[$];
    bit  pop_last[$];
    int  pop_cyc[$];

    sa_ram_rd_stream_128x11 dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .ram_ra          (ram_ra),
        .ram_re          (ram_re),
        .ram_ore         (ram_ore),
        .ram_dout        (ram_dout),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .dout_pd         (dout_pd),
        .dout_last       (dout_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: address captured on ram_re, output register loaded on ram_ore
    always @(posedge clk) begin
        if (ram_re) ra_lat <= ram_ra;
        if (ram_ore) dout_reg <= mem[ra_lat];
    end
    assign ram_dout = dout_reg;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) dout_ready = 1'b1;
            else if (rdy_mode == 1) dout_ready = 1'b0;
            else dout_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk_eq("rst_outputs_zero",
                   int'({ram_re, ram_ore, ram_ra, dout_valid, dout_pd, dout_last}), 0);
            exp_pd.delete();
            exp_last.delete();
            exp_ra.delete();
            busy = 0;
            outst = 0;
            prev_re = 0;
            prev_stall = 0;
            last_ra = 0;
            first_re_pending = 0;
        end else begin
            chk_eq("cmd_ready", int'(cmd_ready), int'(!busy));
            chk_eq("ore_after_re", int'(ram_ore), int'(prev_re));
            if (ram_re) begin
                if (first_re_pending) begin
                    chk_eq("first_re_latency", cyc, first_re_due);
                    first_re_pending = 0;
                end
                if (exp_ra.size() == 0) chk_eq("unexpected_re", 1, 0);
                else chk_eq("ram_ra", int'(ram_ra), exp_ra.pop_front());
                re_log.push_back(int'(ram_ra));
                last_ra = int'(ram_ra);
                outst++;
            end else begin
                chk_eq("ra_hold", int'(ram_ra), last_ra);
            end
            if (prev_stall) begin
                chk_eq("stall_valid", int'(dout_valid), 1);
                chk_eq("stall_pd_stable", int'({dout_last, dout_pd}), prev_word);
            end
            if (dout_valid && dout_ready) begin
                if (exp_pd.size() == 0) begin
                    chk_eq("unexpected_word", 1, 0);
                end else begin
                    int e;
                    bit el;
                    e  = exp_pd.pop_front();
                    el = exp_last.pop_front();
                    chk_eq("dout_pd", int'(dout_pd), e);
                    chk_eq("dout_last", int'(dout_last), int'(el));
                    if (el) busy = 0;
                end
                pop_pd.push_back(int'(dout_pd));
                pop_last.push_back(dout_last);
                pop_cyc.push_back(cyc);
                outst--;
            end
            chk_eq("occupancy_le4", int'(outst <= 4), 1);
            prev_re    = ram_re;
            prev_stall = dout_valid && !dout_ready;
            prev_word  = int'({dout_last, dout_pd});
            if (cmd_valid && cmd_ready) begin
                busy = 1;
                acc_cyc.push_back(cyc);
                first_re_pending = 1;
                first_re_due = cyc + 1;
                for (int k = 0; k <= int'(cmd_len); k++) begin
                    int a;
                    a = (int'(cmd_addr) + k) % 128;
                    exp_ra.push_back(a);
                    exp_pd.push_back(int'(mem[a]));
                    exp_last.push_back(k == int'(cmd_len));
                end
            end
        end
    end

    task automatic clear_logs();
        acc_cyc.delete();
        re_log.delete();
        pop_pd.delete();
        pop_last.delete();
        pop_cyc.delete();
    endtask

    task automatic send_cmd(input int a, input int l);
        @(posedge clk);
        #1;
        cmd_addr  = 7'(a);
        cmd_len   = 7'(l);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        chk_eq("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            if (!busy && exp_pd.size() == 0) return;
        end
        chk_eq("drain_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 11'(i);
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("post_reset_cmd_ready", int'(cmd_ready), 1);
        chk_eq("post_reset_dout_valid", int'(dout_valid), 0);

        // burst 5..8 at full rate
        clear_logs();
        send_cmd(5, 3);
        wait_drain();
        chk_eq("t1_count", pop_pd.size(), 4);
        if (pop_pd.size() == 4) begin
            chk_eq("t1_w0", pop_pd[0], 5);
            chk_eq("t1_w1", pop_pd[1], 6);
            chk_eq("t1_w2", pop_pd[2], 7);
            chk_eq("t1_w3", pop_pd[3], 8);
            chk_eq("t1_last_flags", int'({pop_last[0], pop_last[1], pop_last[2], pop_last[3]}), 1);
            chk_eq("t1_first_pop_latency", pop_cyc[0] - acc_cyc[0], 4);
            chk_eq("t1_back_to_back", pop_cyc[3] - pop_cyc[0], 3);
        end

        // address wrap 126,127,0,1
        clear_logs();
        send_cmd(126, 3);
        wait_drain();
        chk_eq("t2_re_count", re_log.size(), 4);
        if (re_log.size() == 4 && pop_pd.size() == 4) begin
            chk_eq("t2_ra0", re_log[0], 126);
            chk_eq("t2_ra1", re_log[1], 127);
            chk_eq("t2_ra2", re_log[2], 0);
            chk_eq("t2_ra3", re_log[3], 1);
            chk_eq("t2_w1", pop_pd[1], 127);
            chk_eq("t2_w2", pop_pd[2], 0);
        end

        // full-length burst stalled for 20 cycles
        clear_logs();
        rdy_mode = 1;
        send_cmd(10, 127);
        repeat (20) @(posedge clk);
        chk_eq("t3_stalled_re_pulses", re_log.size(), 4);
        @(negedge clk);
        chk_eq("t3_stalled_valid", int'(dout_valid), 1);
        chk_eq("t3_stalled_head", int'(dout_pd), 10);
        @(posedge clk);
        rdy_mode = 0;
        wait_drain();
        chk_eq("t3_word_count", pop_pd.size(), 128);
        if (pop_pd.size() == 128) chk_eq("t3_final_word", pop_pd[127], 9);

        // random data and back-pressure
        for (int i = 0; i < 128; i++) mem[i] = 11'($urandom_range(0, 2047));
        rdy_mode = 2;
        clear_logs();
        send_cmd(int'($urandom_range(0, 127)), 15);
        wait_drain();
        chk_eq("t4_word_count", pop_pd.size(), 16);
        for (int b = 0; b < 6; b++) begin
            send_cmd(int'($urandom_range(0, 127)), int'($urandom_range(0, 40)));
            wait_drain();
        end

        // reset in the middle of a burst
        rdy_mode = 0;
        for (int i = 0; i < 128; i++) mem[i] = 11'(i);
        mem[0] = 11'h2AA;
        clear_logs();
        send_cmd(20, 9);
        for (int i = 0; i < 200 && pop_pd.size() < 3; i++) @(posedge clk);
        chk_eq("t5_reached_word3", int'(pop_pd.size() >= 3), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("t5_async_zero",
               int'({ram_re, ram_ore, ram_ra, dout_valid, dout_pd, dout_last}), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        clear_logs();
        send_cmd(0, 0);
        wait_drain();
        chk_eq("t5_single_count", pop_pd.size(), 1);
        if (pop_pd.size() == 1) begin
            chk_eq("t5_single_pd", pop_pd[0], 'h2AA);
            chk_eq("t5_single_last", int'(pop_last[0]), 1);
        end

        // cmd_valid held through a burst
        clear_logs();
        @(posedge clk);
        #1;
        cmd_addr  = 7'd40;
        cmd_len   = 7'd3;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && acc_cyc.size() < 2; i++) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk_eq("t6_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2 && pop_cyc.size() >= 4) begin
            chk_eq("t6_second_accept_gap", acc_cyc[1] - acc_cyc[0], 8);
            chk_eq("t6_after_last_pop", int'(acc_cyc[1] > pop_cyc[3]), 1);
        end
        wait_drain();
        chk_eq("t6_word_count", pop_pd.size(), 8);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
